// File: rtl/vcve2_clk_sleep_ctrl.sv
// Per-hart clock-enable and sleep controller: sticky fetch enable, OR-ed wake
// sources, programmable idle hysteresis before gating, saturating sleep counter.
module vcve2_clk_sleep_ctrl #(
  parameter int unsigned NumCh    = 1,
  parameter int unsigned NumWake  = 4,
  parameter int unsigned IdleHold = 0,
  parameter int unsigned CntWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               test_en_i,
  input  logic [NumCh-1:0]                   fetch_enable_i,
  input  logic [NumCh-1:0]                   busy_i,
  input  logic [NumCh-1:0][NumWake-1:0]      wake_i,
  output logic [NumCh-1:0]                   fetch_en_o,
  output logic [NumCh-1:0]                   clock_en_o,
  output logic [NumCh-1:0]                   sleep_o,
  output logic [NumCh-1:0][CntWidth-1:0]     sleep_cnt_o
);

  // Idle counter needs at least one bit even when no hysteresis is configured
  localparam int unsigned IdleW = (IdleHold > 0) ? $clog2(IdleHold + 1) : 1;
  localparam logic [CntWidth-1:0] SleepCntMax = '1;
  localparam logic [IdleW-1:0]    IdleLast    = IdleW'(IdleHold);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StSleep = 2'd3
  } state_e;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    state_e                state_q;
    logic                  busy_q;
    logic [IdleW-1:0]      cnt_q;
    logic                  fetch_en_q;
    logic [CntWidth-1:0]   sleep_cnt_q;
    logic [CntWidth-1:0]   sleep_cnt_inc;
    logic                  any_wake;
    logic                  active;
    logic                  clock_en;

    assign any_wake      = |wake_i[c];
    assign active        = busy_q | any_wake;
    assign sleep_cnt_inc = (sleep_cnt_q == SleepCntMax) ? sleep_cnt_q
                                                        : sleep_cnt_q + CntWidth'(1);

    // Channel state machine, busy sampling, sticky fetch enable and sleep counter
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q     <= StOff;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
        fetch_en_q  <= 1'b0;
        sleep_cnt_q <= '0;
      end else begin
        busy_q <= busy_i[c];
        if (fetch_enable_i[c]) begin
          fetch_en_q <= 1'b1;
        end
        unique case (state_q)
          StOff: begin
            if (fetch_en_q) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end
          end
          StRun: begin
            if (active) begin
              cnt_q <= '0;
            end else if (IdleHold == 0) begin
              state_q     <= StSleep;
              sleep_cnt_q <= sleep_cnt_inc;
            end else begin
              state_q <= StDrain;
              cnt_q   <= IdleW'(1);
            end
          end
          StDrain: begin
            if (active) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end else if (cnt_q == IdleLast) begin
              state_q     <= StSleep;
              sleep_cnt_q <= sleep_cnt_inc;
            end else begin
              cnt_q <= cnt_q + IdleW'(1);
            end
          end
          StSleep: begin
            if (active) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= StOff;
          end
        endcase
      end
    end

    // Wake path is combinational so a sleeping hart regains its clock in the same cycle
    assign clock_en = test_en_i
                    | (state_q == StRun)
                    | (state_q == StDrain)
                    | ((state_q == StSleep) & any_wake);

    assign clock_en_o[c]  = clock_en;
    assign sleep_o[c]     = (state_q == StSleep) & ~clock_en;
    assign fetch_en_o[c]  = fetch_en_q;
    assign sleep_cnt_o[c] = sleep_cnt_q;
  end

endmodule

// File: tb/tb_vcve2_clk_sleep_ctrl.sv
// Directed bench: a 2-channel instance with 4 cycles of idle hysteresis and a
// 1-channel instance with no hysteresis and a 2-bit saturating sleep counter.
module tb_vcve2_clk_sleep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic test_en;

  // Instance A: NumCh=2, IdleHold=4, CntWidth=16
  logic [1:0]        fetch_a, busy_a;
  logic [1:0][3:0]   wake_a;
  logic [1:0]        fetch_en_a, clk_en_a, sleep_a;
  logic [1:0][15:0]  cnt_a;

  // Instance B: NumCh=1, IdleHold=0, CntWidth=2
  logic [0:0]        fetch_b, busy_b;
  logic [0:0][3:0]   wake_b;
  logic [0:0]        fetch_en_b, clk_en_b, sleep_b;
  logic [0:0][1:0]   cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  vcve2_clk_sleep_ctrl #(
    .NumCh(2), .NumWake(4), .IdleHold(4), .CntWidth(16)
  ) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_en_i      (test_en),
    .fetch_enable_i (fetch_a),
    .busy_i         (busy_a),
    .wake_i         (wake_a),
    .fetch_en_o     (fetch_en_a),
    .clock_en_o     (clk_en_a),
    .sleep_o        (sleep_a),
    .sleep_cnt_o    (cnt_a)
  );

  vcve2_clk_sleep_ctrl #(
    .NumCh(1), .NumWake(4), .IdleHold(0), .CntWidth(2)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_en_i      (test_en),
    .fetch_enable_i (fetch_b),
    .busy_i         (busy_b),
    .wake_i         (wake_b),
    .fetch_en_o     (fetch_en_b),
    .clock_en_o     (clk_en_b),
    .sleep_o        (sleep_b),
    .sleep_cnt_o    (cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0;
    fetch_a = '0; busy_a = '0; wake_a = '0;
    fetch_b = '0; busy_b = '0; wake_b = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_fetch_a", 32'(fetch_en_a), 32'h0);
    chk("rst_clken_a", 32'(clk_en_a), 32'h0);
    chk("rst_sleep_a", 32'(sleep_a), 32'h0);
    chk("rst_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_clken_b", 32'(clk_en_b), 32'h0);
    chk("rst_cnt_b", 32'(cnt_b), 32'h0);

    // One-cycle fetch enable on ch0: latched next edge, RUN the edge after
    fetch_a = 2'b01; busy_a = 2'b01;
    tick();
    fetch_a = 2'b00;
    chk("fetch_latched", 32'(fetch_en_a), 32'h1);
    chk("off_still_gated", 32'(clk_en_a), 32'h0);
    tick();
    chk("run_clken", 32'(clk_en_a), 32'h1);
    chk("run_sleep", 32'(sleep_a), 32'h0);
    tick();
    chk("fetch_sticky", 32'(fetch_en_a), 32'h1);
    chk("busy_run_clken", 32'(clk_en_a), 32'h1);

    // busy falls: clock held 5 more cycles (1 sample + 4 hysteresis), then gated
    busy_a = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain_clken", 32'(clk_en_a[0]), 32'h1);
    end
    tick();
    chk("gated_clken", 32'(clk_en_a[0]), 32'h0);
    chk("gated_sleep", 32'(sleep_a[0]), 32'h1);
    chk("sleep_cnt_1", 32'(cnt_a[0]), 32'h1);
    chk("ch1_untouched", 32'(clk_en_a[1]), 32'h0);
    tick(); tick();
    chk("sleep_holds", 32'(sleep_a), 32'h1);

    // Same-cycle wake, then re-gate after hysteresis
    wake_a[0][1] = 1'b1;
    #1;
    chk("wake_comb_clken", 32'(clk_en_a[0]), 32'h1);
    chk("wake_comb_sleep", 32'(sleep_a[0]), 32'h0);
    tick();
    wake_a = '0;
    chk("wake_run_clken", 32'(clk_en_a[0]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rewake_drain", 32'(clk_en_a[0]), 32'h1);
    end
    tick();
    chk("regated_clken", 32'(clk_en_a[0]), 32'h0);
    chk("sleep_cnt_2", 32'(cnt_a[0]), 32'h2);

    // Wake on the last DRAIN cycle cancels sleep entry
    wake_a[0][0] = 1'b1;
    tick();
    wake_a = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cancel_drain", 32'(clk_en_a[0]), 32'h1);
    end
    wake_a[0][2] = 1'b1;
    #1;
    chk("cancel_comb", 32'(clk_en_a[0]), 32'h1);
    tick();
    wake_a = '0;
    chk("cancel_clken", 32'(clk_en_a[0]), 32'h1);
    chk("cancel_sleep", 32'(sleep_a[0]), 32'h0);
    chk("cancel_cnt", 32'(cnt_a[0]), 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cancel_redrain", 32'(clk_en_a[0]), 32'h1);
    end
    tick();
    chk("cancel_regated", 32'(clk_en_a[0]), 32'h0);
    chk("sleep_cnt_3", 32'(cnt_a[0]), 32'h3);

    // Test override forces enables without touching state
    test_en = 1'b1;
    #1;
    chk("test_clken", 32'(clk_en_a), 32'h3);
    chk("test_sleep", 32'(sleep_a), 32'h0);
    tick(); tick();
    chk("test_clken_hold", 32'(clk_en_a), 32'h3);
    chk("test_cnt", 32'(cnt_a[0]), 32'h3);
    test_en = 1'b0;
    #1;
    chk("test_off_clken", 32'(clk_en_a), 32'h0);
    chk("test_off_sleep", 32'(sleep_a), 32'h1);

    // Reset while asleep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_fetch", 32'(fetch_en_a), 32'h0);
    chk("rst2_cnt", 32'(cnt_a), 32'h0);
    chk("rst2_clken", 32'(clk_en_a), 32'h0);
    chk("rst2_sleep", 32'(sleep_a), 32'h0);
    tick();
    chk("rst2_stays_off", 32'(clk_en_a), 32'h0);

    // No hysteresis: sleep one cycle after busy_q drops; 2-bit counter saturates
    fetch_b = 1'b1; busy_b = 1'b1;
    tick();
    fetch_b = 1'b0;
    tick();
    chk("b_run", 32'(clk_en_b), 32'h1);
    busy_b = 1'b0;
    tick();
    chk("b_busyq_low", 32'(clk_en_b), 32'h1);
    tick();
    chk("b_gated", 32'(clk_en_b), 32'h0);
    chk("b_sleep", 32'(sleep_b), 32'h1);
    chk("b_cnt_1", 32'(cnt_b), 32'h1);
    exp_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      wake_b[0][3] = 1'b1;
      #1;
      chk("b_wake_comb", 32'(clk_en_b), 32'h1);
      tick();
      wake_b = '0;
      chk("b_wake_run", 32'(clk_en_b), 32'h1);
      tick();
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      chk("b_regated", 32'(clk_en_b), 32'h0);
      chk("b_cnt_sat", 32'(cnt_b), 32'(exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
